dip_switch_debouncer: RTL and testbench
=======================================

# dip_switch_debouncer

Input conditioning stage between the two 4-bit DIP switch banks and the lab 2 display/adder datapath. Each bank is resynchronized to `clk`, then debounced as a 4-bit vector: the clean value updates only after the synchronized input has held one new value for `DEBOUNCE_CYCLES` consecutive cycles. The clean `s1`/`s2` outputs drive the seven-segment mux and the adder, which therefore never see metastable or bouncing values. A per-bank one-cycle change strobe is available to downstream logic.

## Interface
- `DEBOUNCE_CYCLES`, default 240000: consecutive stable cycles required before the output updates; 5 ms at the 48 MHz HSOSC clock; legal range ≥ 2.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES+1)`: counter width; derived, never overridden.
- `clk`  in  1  system clock from HSOSC `CLKHF`.
- `reset`  in  1  synchronous, active-low reset.
- `s1_raw`  in  4  raw DIP bank 1, asynchronous to `clk`.
- `s2_raw`  in  4  raw DIP bank 2, asynchronous to `clk`.
- `s1`  out  4  debounced bank 1 value.
- `s2`  out  4  debounced bank 2 value.
- `s1_chg`  out  1  one-cycle pulse when `s1` updates.
- `s2_chg`  out  1  one-cycle pulse when `s2` updates.

## Operation
- Each bank is processed by an identical, independent slice. Bank 1 and bank 2 share no state.
- Synchronizer: 2-flop chain per bit (`sync1`, `sync2`). Debounce logic uses only `sync2`.
- Per-slice registers:
  - `cand` (4 b): candidate value.
  - `cnt` (`CNT_W` b): consecutive-cycle counter.
  - `out` (4 b): debounced value.
  - `chg` (1 b): change strobe.
- Per-slice two-state FSM:
  - IDLE: `sync2 == out`.
    - `cnt` is held at 0.
    - If `sync2 != out`: `cand <= sync2`, `cnt <= 1`, go to COUNT.
  - COUNT, evaluated in this priority order:
    - If `sync2 == out` (input bounced back): `cnt <= 0`, go to IDLE. No output change.
    - Else if `sync2 != cand`: `cand <= sync2`, `cnt <= 1`, stay in COUNT (restart on the new value).
    - Else if `cnt == DEBOUNCE_CYCLES-1`: `out <= cand`, `chg <= 1`, `cnt <= 0`, go to IDLE.
    - Else: `cnt <= cnt + 1`.
- `chg` is 1 for exactly one cycle per update and is 0 in every other cycle.
- Debounce operates on the whole 4-bit vector. A multi-bit change that settles within the window produces a single update with a single strobe.
- Counter arithmetic is unsigned and never exceeds `DEBOUNCE_CYCLES-1`, so no wrap-around is possible.

## Timing
- Reset, when `reset == 0` at a rising edge:
  - `sync1`, `sync2`, `cand`, `out` = 4'h0; `cnt` = 0; `chg` = 0; FSM = IDLE.
  - So after reset: `s1 = s2 = 4'h0` and `s1_chg = s2_chg = 0`.
- Reset asserted mid-count discards the count. After release, a raw value still held ≠ 0 restarts the full latency below.
- Latency: raw value changes before edge k and stays stable.
  - `sync2` shows the new value after edge k+1.
  - `out` updates at edge k+1+`DEBOUNCE_CYCLES`.
  - `chg` is high for the cycle following that edge.
- Glitch rejection: a raw change lasting fewer than `DEBOUNCE_CYCLES` synchronized cycles never reaches `out`.
- Simultaneous updates on both banks in the same cycle are legal; both strobes assert together.
- A new raw change arriving in the same cycle as an update begins a fresh IDLE→COUNT sequence on the following edge.

## Configuration
- Macro: `DIP_DEBOUNCE_ACTIVE_LOW_EN`.
- Defined: raw inputs are inverted before `sync1` (`~s1_raw`, `~s2_raw`), for boards with pulled-up switches. Reset values are unchanged (all 0 after inversion point).
- Undefined: raw inputs are used as-is (switch on = 1).

## Test plan
All scenarios use `DEBOUNCE_CYCLES = 4` with no macro unless stated.
1. Reset: hold `reset = 0` for 3 cycles with `s1_raw = 4'hA` → `s1 = 0`, `s1_chg = 0` throughout. After release with `4'hA` held, `s1 = 4'hA` exactly 5 edges later and `s1_chg` pulses once.
2. Glitch: `s2_raw` goes 0→`4'h3` for 3 cycles, then back to 0 → `s2` stays 0 and `s2_chg` never asserts.
3. Bounce-then-settle: `s1_raw` sequence `4'h5`, `4'h1`, `4'h5`, then `4'h5` held → exactly one update to `4'h5`, 5 edges after the final change, with a single strobe.
4. Both banks: `s1_raw = 4'hF` and `s2_raw = 4'h9` change on the same edge → `s1` and `s2` update on the same edge, and `s1_chg` and `s2_chg` pulse together.
5. Mid-count reset: `s2_raw = 4'hC`, reset asserted after 2 counting cycles for 1 cycle → `s2 = 0`, then update to `4'hC` a full 5 edges after release.
6. With `DIP_DEBOUNCE_ACTIVE_LOW_EN` defined: `s1_raw = 4'hE` held → `s1 = 4'h1`.

Source files
------------

// File: rtl/dip_switch_debouncer.sv
// dip_switch_debouncer: resynchronize and debounce two 4-bit DIP switch banks
//
// Optional feature macro: DIP_DEBOUNCE_ACTIVE_LOW_EN
//   defined   -> raw inputs are inverted before the synchronizer (pulled-up switches)
//   undefined -> raw inputs are used as-is (switch on = 1)
//
// Ports:
//   clk     in   system clock (HSOSC CLKHF)
//   reset   in   synchronous, active-low reset
//   s1_raw  in   raw DIP bank 1, asynchronous to clk
//   s2_raw  in   raw DIP bank 2, asynchronous to clk
//   s1      out  debounced bank 1 value
//   s2      out  debounced bank 2 value
//   s1_chg  out  one-cycle pulse when s1 updates
//   s2_chg  out  one-cycle pulse when s2 updates

// dip_debounce_slice: one bank's synchronizer plus vector debounce FSM
//
// Ports:
//   clk, reset  as above
//   raw         polarity-corrected raw bank input
//   out         debounced value
//   chg         one-cycle update strobe
module dip_debounce_slice #(
    parameter int DEBOUNCE_CYCLES = 240000,
    parameter int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] raw,
    output logic [3:0] out,
    output logic       chg
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] COUNT = 1'b1;

    logic [3:0]       sync1;
    logic [3:0]       sync2;
    logic [3:0]       cand;
    logic [CNT_W-1:0] cnt;
    logic [0:0]       state;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1 <= 4'h0;
            sync2 <= 4'h0;
            cand  <= 4'h0;
            out   <= 4'h0;
            cnt   <= '0;
            chg   <= 1'b0;
            state <= IDLE;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            chg   <= 1'b0;
            if (state == IDLE) begin
                if (sync2 != out) begin
                    cand  <= sync2;
                    cnt   <= CNT_W'(1);
                    state <= COUNT;
                end else begin
                    cnt <= '0;
                end
            end else if (sync2 == out) begin
                // bounced back to the current value: abandon the candidate
                cnt   <= '0;
                state <= IDLE;
            end else if (sync2 != cand) begin
                // settled on yet another value: restart the window on it
                cand <= sync2;
                cnt  <= CNT_W'(1);
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                out   <= cand;
                chg   <= 1'b1;
                cnt   <= '0;
                state <= IDLE;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end
endmodule

module dip_switch_debouncer #(
    parameter int DEBOUNCE_CYCLES = 240000,
    parameter int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] s1_raw,
    input  logic [3:0] s2_raw,
    output logic [3:0] s1,
    output logic [3:0] s2,
    output logic       s1_chg,
    output logic       s2_chg
);
    logic [3:0] s1_in;
    logic [3:0] s2_in;

`ifdef DIP_DEBOUNCE_ACTIVE_LOW_EN
    assign s1_in = ~s1_raw;
    assign s2_in = ~s2_raw;
`else
    assign s1_in = s1_raw;
    assign s2_in = s2_raw;
`endif

    dip_debounce_slice #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_bank1 (
        .clk   (clk),
        .reset (reset),
        .raw   (s1_in),
        .out   (s1),
        .chg   (s1_chg)
    );

    dip_debounce_slice #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_bank2 (
        .clk   (clk),
        .reset (reset),
        .raw   (s2_in),
        .out   (s2),
        .chg   (s2_chg)
    );
endmodule

// File: tb/tb_dip_switch_debouncer.sv
// tb_dip_switch_debouncer: scoreboard bench for dip_switch_debouncer with DEBOUNCE_CYCLES = 4
module tb_dip_switch_debouncer;
    typedef struct {
        logic [3:0] val;
        int         cyc;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] s1_raw;
    logic [3:0] s2_raw;
    logic [3:0] s1;
    logic [3:0] s2;
    logic       s1_chg;
    logic       s2_chg;

    int  cyc = 0;
    int  tests = 0;
    int  fails = 0;
    ev_t q1[$];
    ev_t q2[$];

    dip_switch_debouncer #(.DEBOUNCE_CYCLES(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .s1_raw (s1_raw),
        .s2_raw (s2_raw),
        .s1     (s1),
        .s2     (s2),
        .s1_chg (s1_chg),
        .s2_chg (s2_chg)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] phys(input logic [3:0] v);
`ifdef DIP_DEBOUNCE_ACTIVE_LOW_EN
        return ~v;
`else
        return v;
`endif
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push1(input logic [3:0] v, input int c);
        ev_t e;
        e.val = v;
        e.cyc = c;
        q1.push_back(e);
    endtask

    task automatic push2(input logic [3:0] v, input int c);
        ev_t e;
        e.val = v;
        e.cyc = c;
        q2.push_back(e);
    endtask

    // Monitor: every strobe must match the head of its bank's queue in value and cycle;
    // an expected event whose cycle passes without a strobe is reported as missing.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (s1_chg === 1'b1) begin
                tests++;
                if (q1.size() == 0) begin
                    fails++;
                    $display("FAIL s1_unexpected_strobe: s1=%h at cycle %0d, none expected", s1, cyc);
                end else begin
                    ev_t e;
                    e = q1.pop_front();
                    if (s1 !== e.val || cyc != e.cyc) begin
                        fails++;
                        $display("FAIL s1_update: got %h at cycle %0d, expected %h at cycle %0d", s1, cyc, e.val, e.cyc);
                    end
                end
            end else if (q1.size() > 0 && q1[0].cyc <= cyc) begin
                tests++;
                fails++;
                $display("FAIL s1_missing_strobe: s1=%h at cycle %0d, expected %h", s1, cyc, q1[0].val);
                void'(q1.pop_front());
            end
            if (s2_chg === 1'b1) begin
                tests++;
                if (q2.size() == 0) begin
                    fails++;
                    $display("FAIL s2_unexpected_strobe: s2=%h at cycle %0d, none expected", s2, cyc);
                end else begin
                    ev_t e;
                    e = q2.pop_front();
                    if (s2 !== e.val || cyc != e.cyc) begin
                        fails++;
                        $display("FAIL s2_update: got %h at cycle %0d, expected %h at cycle %0d", s2, cyc, e.val, e.cyc);
                    end
                end
            end else if (q2.size() > 0 && q2[0].cyc <= cyc) begin
                tests++;
                fails++;
                $display("FAIL s2_missing_strobe: s2=%h at cycle %0d, expected %h", s2, cyc, q2[0].val);
                void'(q2.pop_front());
            end
        end
    end

    initial begin
        int e;
        reset  = 1'b0;
        s1_raw = phys(4'hA);
        s2_raw = phys(4'h0);
        step(1);
        // 1. reset holds outputs at zero, then a held value appears after the full latency
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("reset_s1", {s1_chg, s1}, 5'h00);
            check("reset_s2", {s2_chg, s2}, 5'h00);
        end
        reset = 1'b1;
        e = cyc;
        push1(4'hA, e + 6);
        step(12);
        check("s1_after_reset", {1'b0, s1}, {1'b0, 4'hA});
        // 2. short glitch on bank 2 is rejected
        s2_raw = phys(4'h3);
        step(3);
        s2_raw = phys(4'h0);
        step(12);
        check("s2_glitch", {1'b0, s2}, 5'h00);
        // 3. bounce then settle on bank 1
        s1_raw = phys(4'h5);
        e = cyc;
        step(1);
        s1_raw = phys(4'h1);
        step(1);
        s1_raw = phys(4'h5);
        push1(4'h5, e + 8);
        step(12);
        check("s1_bounce_settle", {1'b0, s1}, {1'b0, 4'h5});
        // 4. both banks change together
        s1_raw = phys(4'hF);
        s2_raw = phys(4'h9);
        e = cyc;
        push1(4'hF, e + 6);
        push2(4'h9, e + 6);
        step(12);
        // 5. reset in the middle of a count discards it
        s2_raw = phys(4'hC);
        step(3);
        reset = 1'b0;
        step(1);
        check("midreset_s1", {s1_chg, s1}, 5'h00);
        check("midreset_s2", {s2_chg, s2}, 5'h00);
        reset = 1'b1;
        e = cyc;
        push1(4'hF, e + 6);
        push2(4'hC, e + 6);
        step(12);
        // 6. raw value driven without polarity correction
        s1_raw = 4'hE;
        e = cyc;
`ifdef DIP_DEBOUNCE_ACTIVE_LOW_EN
        push1(4'h1, e + 6);
`else
        push1(4'hE, e + 6);
`endif
        step(12);
        check("q1_drained", {1'b0, 4'(q1.size())}, 5'h00);
        check("q2_drained", {1'b0, 4'(q2.size())}, 5'h00);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
